// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave that runs timed HD44780 bus cycles (setup, E pulse, hold).
// Define LCD_BUSY_POLL_EN to replace the fixed post-write delay with DB7 polling.
module lcd_bus_sequencer #(
  parameter int T_SETUP     = 3,
  parameter int T_EPW       = 12,
  parameter int T_HOLD      = 3,
  parameter int T_WAIT      = 2000,
  parameter int T_WAIT_LONG = 82000,
  parameter int POLL_MAX    = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] avs_address,
  input  logic       avs_read,
  input  logic       avs_write,
  input  logic [7:0] avs_writedata,
  output logic [7:0] avs_readdata,
  output logic       avs_waitrequest,
  output logic       lcd_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int CW = $clog2(T_WAIT_LONG + 1);
  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] L_EPW   = CW'(T_EPW - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] L_WAIT  = CW'(T_WAIT - 1);
  localparam logic [CW-1:0] L_LONG  = CW'(T_WAIT_LONG - 1);

  if (T_SETUP < 1 || T_EPW < 1 || T_HOLD < 1 || T_WAIT < 1 ||
      T_WAIT_LONG < 1 || POLL_MAX < 1) begin : g_bad_param
    $error("lcd_bus_sequencer: every timing parameter must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EHIGH, S_HOLD, S_ACK, S_BUSY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rs_q, rs_d, rw_q, rw_d, wr_q, wr_d;
  logic [7:0]      dat_q, dat_d, rdata_q, rdata_d;
  logic            e_q, e_d, rsp_q, rsp_d, rwp_q, rwp_d, oe_q, oe_d;
  logic            act_d, long_w;

`ifdef LCD_BUSY_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] P_LAST = PW'(POLL_MAX - 1);
  logic            poll_q, poll_d, db7_q, db7_d, tmo_q, tmo_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
`endif

  // Clear/home commands need the long post-write delay.
  assign long_w = ~rs_q & (dat_q != 8'h00) & (dat_q <= 8'h03);

  // Next-state, counter, latched access and registered-pin targets.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    wr_d    = wr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
`ifdef LCD_BUSY_POLL_EN
    poll_d  = poll_q;
    pcnt_d  = pcnt_q;
    db7_d   = db7_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (avs_write | avs_read) begin
          rs_d    = avs_address[1];
          rw_d    = avs_address[0];
          wr_d    = avs_write;
          dat_d   = avs_writedata;
          state_d = S_SETUP;
          cnt_d   = L_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EHIGH;
          cnt_d   = L_EPW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EHIGH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = L_HOLD;
`ifdef LCD_BUSY_POLL_EN
          if (poll_q) db7_d = LCD_data[7];
          else if (!wr_q) rdata_d = LCD_data;
`else
          if (!wr_q) rdata_d = LCD_data;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
`ifdef LCD_BUSY_POLL_EN
          if (!poll_q) begin
            state_d = S_ACK;
          end else if (!db7_q) begin
            state_d = S_IDLE;
            poll_d  = 1'b0;
          end else if (pcnt_q == P_LAST) begin
            state_d = S_IDLE;
            poll_d  = 1'b0;
            tmo_d   = 1'b1;
          end else begin
            pcnt_d  = pcnt_q + 1'b1;
            state_d = S_SETUP;
            cnt_d   = L_SETUP;
          end
`else
          state_d = S_ACK;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        if (wr_q & ~rw_q) begin
`ifdef LCD_BUSY_POLL_EN
          state_d = S_SETUP;
          cnt_d   = L_SETUP;
          poll_d  = 1'b1;
          pcnt_d  = '0;
`else
          state_d = S_BUSY;
          cnt_d   = long_w ? L_LONG : L_WAIT;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    act_d = state_d inside {S_SETUP, S_EHIGH, S_HOLD};
    e_d   = (state_d == S_EHIGH);
`ifdef LCD_BUSY_POLL_EN
    rsp_d = act_d & ~poll_d & rs_d;
    rwp_d = ~act_d | poll_d | rw_d;
    oe_d  = act_d & ~poll_d & wr_d & ~rw_d;
`else
    rsp_d = act_d & rs_d;
    rwp_d = ~act_d | rw_d;
    oe_d  = act_d & wr_d & ~rw_d;
`endif
  end

  // State, counter and pin registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      wr_q    <= 1'b0;
      dat_q   <= 8'h00;
      rdata_q <= 8'h00;
      e_q     <= 1'b0;
      rsp_q   <= 1'b0;
      rwp_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      wr_q    <= wr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      e_q     <= e_d;
      rsp_q   <= rsp_d;
      rwp_q   <= rwp_d;
      oe_q    <= oe_d;
    end
  end

`ifdef LCD_BUSY_POLL_EN
  // Poll bookkeeping and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_q <= 1'b0;
      pcnt_q <= '0;
      db7_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      poll_q <= poll_d;
      pcnt_q <= pcnt_d;
      db7_q  <= db7_d;
      tmo_q  <= tmo_d;
    end
  end
  assign lcd_timeout = tmo_q;
`else
  assign lcd_timeout = 1'b0;
`endif

  assign avs_waitrequest = (avs_read | avs_write) & (state_q != S_ACK);
  assign avs_readdata    = rdata_q;
  assign LCD_E           = e_q;
  assign LCD_RS          = rsp_q;
  assign LCD_RW          = rwp_q;
  assign LCD_data        = oe_q ? dat_q : 8'hzz;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Randomised self-checking bench for lcd_bus_sequencer.
// Model: timing from parameter arithmetic plus a "controller free at edge" tracker.
module tb_lcd_bus_sequencer;

  localparam int TS  = 3;
  localparam int TE  = 12;
  localparam int TH  = 3;
  localparam int TW  = 50;
  localparam int TWL = 400;
  localparam int PM  = 16;
  localparam int TC  = TS + TE + TH;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] addr;
  logic       rd, wr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wreq, tmo, e, rs, rw;
  wire  [7:0] bus;

  logic [7:0] lcd_val;
  int         cyc = 0;
  int         polls_seen = 0;
  int         busy_thresh;
  int         n_run, n_fail;
  int         free_edge;
  logic [7:0] last_rd;
  logic       exp_tmo;

  lcd_bus_sequencer #(
    .T_SETUP(TS), .T_EPW(TE), .T_HOLD(TH),
    .T_WAIT(TW), .T_WAIT_LONG(TWL), .POLL_MAX(PM)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(addr), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_readdata(rdata),
    .avs_waitrequest(wreq), .lcd_timeout(tmo),
    .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw), .LCD_data(bus)
  );

  // LCD model: drives the bus whenever RW is high; DB7 high while busy.
  assign bus = rw ? ((polls_seen < busy_thresh) ? (lcd_val | 8'h80)
                                                : lcd_val)
                  : 8'hzz;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge e) if (rw && !rs) polls_seen <= polls_seen + 1;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, act, exp, cyc);
    end
  endtask

  function automatic int gap_of(input logic lw, input logic rs_b,
                                input logic [7:0] d, input int bp);
`ifdef LCD_BUSY_POLL_EN
    int p;
    p = (bp + 1 > PM) ? PM : bp + 1;
    return lw ? TC * p : 0;
`else
    if (!lw) return 0;
    return (!rs_b && d >= 8'h01 && d <= 8'h03) ? TWL : TW;
`endif
  endfunction

  task automatic access(input logic w, input logic r, input logic [1:0] a,
                        input logic [7:0] d, input logic [7:0] v,
                        input int rst_k, input int bp);
    int s, k, rk;
    logic lw;
    lw = w & ~a[0];
    rk = rst_k;
    lcd_val = v;
    busy_thresh = polls_seen + bp;
    wr = w; rd = r; addr = a; wdata = d;
    s = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    for (int n = 0; n < 50000; n++) begin
      @(posedge clk);
      @(negedge clk);
      k = cyc - s + 1;
      if (rk != 0 && k == rk) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_e", e, 1'b0);
        check("rst_rw", rw, 1'b1);
        check("rst_bus_released", bus, v);
        check("rst_rdata", rdata, 8'h00);
        reset = 1'b0;
        last_rd = 8'h00;
        exp_tmo = 1'b0;
        s = cyc + 1;
        rk = 0;
        continue;
      end
      if (k < 1) begin
        check("wreq_busy", wreq, 1'b1);
`ifndef LCD_BUSY_POLL_EN
        check("e_busy", e, 1'b0);
`endif
      end else if (k <= TC) begin
        check("wreq_cyc", wreq, 1'b1);
        check("rs", rs, a[1]);
        check("rw", rw, a[0]);
        check("e", e, (k > TS && k <= TS + TE));
        if (lw) check("bus_wr", bus, d);
        else if (a[0]) check("bus_released", bus, v);
      end else begin
        check("wreq_ack", wreq, 1'b0);
        check("tmo", tmo, exp_tmo);
        if (!w) begin
          check("rdata", rdata, v);
          last_rd = v;
        end else begin
          check("rdata_keep", rdata, last_rd);
        end
        free_edge = cyc + 2 + gap_of(lw, a[1], d, bp);
        if (lw && bp >= PM) exp_tmo = 1'b1;
        break;
      end
    end
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    logic       w, r;
    logic [1:0] a;
    logic [7:0] d, v;
    reset = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = 2'b00; wdata = 8'h00;
    lcd_val = 8'h5a; busy_thresh = 0;
    n_run = 0; n_fail = 0;
    last_rd = 8'h00; exp_tmo = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_e", e, 1'b0);
    check("reset_rs", rs, 1'b0);
    check("reset_rw", rw, 1'b1);
    check("reset_rdata", rdata, 8'h00);
    check("reset_tmo", tmo, 1'b0);
    check("reset_wreq", wreq, 1'b0);
    check("reset_bus", bus, 8'h5a);
    reset = 1'b0;
    free_edge = cyc + 1;

    access(1'b1, 1'b0, 2'b00, 8'h38, 8'h5a, 0, 0);
    access(1'b0, 1'b1, 2'b11, 8'h00, 8'hA5, 0, 0);
    access(1'b1, 1'b0, 2'b00, 8'h01, 8'h5a, 0, 0);
    access(1'b1, 1'b0, 2'b10, 8'h41, 8'h5a, 0, 0);
    access(1'b1, 1'b0, 2'b00, 8'h0C, 8'h5a, 0, 0);
    access(1'b1, 1'b0, 2'b10, 8'h42, 8'h5a, 0, 0);
    access(1'b1, 1'b0, 2'b00, 8'h80, 8'h5a, 9, 0);
    access(1'b1, 1'b1, 2'b00, 8'h06, 8'h33, 0, 0);
    access(1'b0, 1'b1, 2'b01, 8'h00, 8'h17, 0, 0);
`ifdef LCD_BUSY_POLL_EN
    access(1'b1, 1'b0, 2'b00, 8'h06, 8'h11, 0, 5);
    access(1'b0, 1'b1, 2'b11, 8'h00, 8'h22, 0, 0);
    access(1'b1, 1'b0, 2'b00, 8'h06, 8'h11, 0, 1000);
    access(1'b0, 1'b1, 2'b11, 8'h00, 8'h44, 0, 0);
`endif

    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      if (!w) a[0] = 1'b1;
      r = !w | ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3))
                                      : 8'($urandom);
      v = 8'($urandom);
`ifdef LCD_BUSY_POLL_EN
      v[7] = 1'b0;
`endif
      access(w, r, a, d, v, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
